// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// Block-move / memory-initialisation engine for the 256x16 data memory.
// After a start command it either copies len words from src to dst, or fills
// dst with a constant pattern. One word moves per cycle through a single
// read-to-write pipeline stage. It reports a 16-bit additive checksum of every
// word it writes.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         command strobe (sampled in IDLE only), 0=copy 1=fill
//   src_addr,dst_addr source / destination base addresses
//   len               word count 0..256 (larger values clamp to 256)
//   pattern           fill word
//   abort             cancels the active command (RUN / DRAIN)
//   busy, done        status: busy in RUN/DRAIN, one-cycle done pulse
//   checksum          sum of written words mod 2^16
//   mem_rd_addr       memory read address (decoded from state and count)
//   mem_read_out      memory combinational read data
//   mem_wt_en, mem_wt_addr, mem_data_wt   memory write port
module mem_copy_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                op,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     len,
    input  logic [DATA_W-1:0]   pattern,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   checksum,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic [DATA_W-1:0]   mem_read_out,
    output logic                mem_wt_en,
    output logic [ADDR_W-1:0]   mem_wt_addr,
    output logic [DATA_W-1:0]   mem_data_wt
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_r;
    logic              op_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [DATA_W-1:0] pattern_r;
    logic [LEN_W-1:0]  k_r;
    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] checksum_r;
    logic              wt_en_r;
    logic [ADDR_W-1:0] wt_addr_r;
    logic [DATA_W-1:0] data_wt_r;

    logic [LEN_W-1:0]  len_clamp_s;
    logic              accept_s;
    logic              last_s;
    logic [DATA_W-1:0] word_s;
    logic [ADDR_W-1:0] rd_addr_s;

    // Command decode: clamp length, pick the captured word, detect last RUN cycle.
    always_comb begin
        len_clamp_s = len;
        if (len > MAX_LEN) begin
            len_clamp_s = MAX_LEN;
        end else begin
            len_clamp_s = len;
        end
        accept_s = (state_r == ST_IDLE) && start;
        last_s   = (k_r == (len_r - LEN_W'(1)));
        if (op_r) begin
            word_s = pattern_r;
        end else begin
            word_s = mem_read_out;
        end
    end

    // Read address is live only in RUN; it walks src+k with natural 8-bit wrap.
    always_comb begin
        if (state_r == ST_RUN) begin
            rd_addr_s = src_r + k_r[ADDR_W-1:0];
        end else begin
            rd_addr_s = {ADDR_W{1'b0}};
        end
    end

    // Main sequencer: state, command latch, count and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            op_r      <= 1'b0;
            src_r     <= {ADDR_W{1'b0}};
            dst_r     <= {ADDR_W{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            pattern_r <= {DATA_W{1'b0}};
            k_r       <= {LEN_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wt_en_r   <= 1'b0;
            wt_addr_r <= {ADDR_W{1'b0}};
            data_wt_r <= {DATA_W{1'b0}};
        end else begin
            // Write port and done idle unless a branch below drives them.
            done_r    <= 1'b0;
            wt_en_r   <= 1'b0;
            wt_addr_r <= {ADDR_W{1'b0}};
            data_wt_r <= {DATA_W{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r      <= op;
                        src_r     <= src_addr;
                        dst_r     <= dst_addr;
                        len_r     <= len_clamp_s;
                        pattern_r <= pattern;
                        k_r       <= {LEN_W{1'b0}};
                        if (len_clamp_s != {LEN_W{1'b0}}) begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // The write already on the port completes at this edge;
                        // no further write is scheduled.
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        // Word captured in cycle k is written to dst+k next cycle.
                        wt_en_r   <= 1'b1;
                        wt_addr_r <= dst_r + k_r[ADDR_W-1:0];
                        data_wt_r <= word_s;
                        k_r       <= k_r + LEN_W'(1);
                        if (last_s) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    busy_r <= 1'b0;
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Checksum: cleared on accept, then adds each word as it is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            checksum_r <= {DATA_W{1'b0}};
        end else if (wt_en_r) begin
            checksum_r <= checksum_r + data_wt_r;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign checksum    = checksum_r;
    assign mem_rd_addr = rd_addr_s;
    assign mem_wt_en   = wt_en_r;
    assign mem_wt_addr = wt_addr_r;
    assign mem_data_wt = data_wt_r;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a 256x16 memory model.
module tb_mem_copy_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [8:0]  len;
    logic [15:0] pattern;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] checksum;
    logic [7:0]  mem_rd_addr;
    logic [15:0] mem_read_out;
    logic        mem_wt_en;
    logic [7:0]  mem_wt_addr;
    logic [15:0] mem_data_wt;

    logic [15:0] mem [0:255];
    logic        tb_we;
    logic [7:0]  tb_waddr;
    logic [15:0] tb_wdata;
    int          wr_total;
    int          done_total;

    int errors;
    int checks;

    mem_copy_engine #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .pattern      (pattern),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum),
        .mem_rd_addr  (mem_rd_addr),
        .mem_read_out (mem_read_out),
        .mem_wt_en    (mem_wt_en),
        .mem_wt_addr  (mem_wt_addr),
        .mem_data_wt  (mem_data_wt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write at rising edge; bench preload port wins.
    assign mem_read_out = mem[mem_rd_addr];
    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end else if (mem_wt_en) begin
            mem[mem_wt_addr] <= mem_data_wt;
        end
        if (mem_wt_en) wr_total <= wr_total + 1;
        if (done)      done_total <= done_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Issue one command, then observe cycles E+1.. until done (bounded).
    task automatic run_cmd(input logic o, input logic [7:0] s, input logic [7:0] d,
                           input logic [8:0] l, input logic [15:0] p,
                           output int n_done, output int nwr, output int first,
                           output int last, output int nbusy);
        @(negedge clk);
        start = 1'b1; op = o; src_addr = s; dst_addr = d; len = l; pattern = p;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = -1; nwr = 0; first = -1; last = -1; nbusy = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (mem_wt_en) begin
                nwr++;
                if (first < 0) first = n;
                last = n;
            end
            if (done) begin
                n_done = n;
                break;
            end
        end
    endtask

    initial begin
        int nd, nw, fw, lw, nb, wr0, dn0;
        errors = 0; checks = 0;
        wr_total = 0; done_total = 0;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; src_addr = 8'h00; dst_addr = 8'h00;
        len = 9'd0; pattern = 16'h0000; abort = 1'b0;
        tb_we = 1'b0; tb_waddr = 8'h00; tb_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'h0);
        chk("rst_wt_en", 32'(mem_wt_en), 32'd0);
        chk("rst_rd_addr", 32'(mem_rd_addr), 32'h0);
        rst_n = 1'b1;

        // Basic copy 0x10..0x13 -> 0x80..0x83
        for (int i = 0; i < 4; i++) preload(8'(8'h10 + i), 16'(i + 1));
        run_cmd(1'b0, 8'h10, 8'h80, 9'd4, 16'h0000, nd, nw, fw, lw, nb);
        chk("copy_done_cycle", 32'(nd), 32'd6);
        chk("copy_nwr", 32'(nw), 32'd4);
        chk("copy_first_wr", 32'(fw), 32'd2);
        chk("copy_last_wr", 32'(lw), 32'd5);
        chk("copy_busy_cycles", 32'(nb), 32'd5);
        chk("copy_checksum", 32'(checksum), 32'h000A);
        chk("copy_m80", 32'(mem[8'h80]), 32'h0001);
        chk("copy_m81", 32'(mem[8'h81]), 32'h0002);
        chk("copy_m82", 32'(mem[8'h82]), 32'h0003);
        chk("copy_m83", 32'(mem[8'h83]), 32'h0004);

        // Wrapping copy 0xFE.. -> 0xFF..
        preload(8'hFE, 16'h1111);
        preload(8'hFF, 16'h2222);
        preload(8'h00, 16'h3333);
        run_cmd(1'b0, 8'hFE, 8'hFF, 9'd3, 16'h0000, nd, nw, fw, lw, nb);
        chk("wrap_done_cycle", 32'(nd), 32'd5);
        chk("wrap_nwr", 32'(nw), 32'd3);
        chk("wrap_mFF", 32'(mem[8'hFF]), 32'h1111);
        chk("wrap_m00", 32'(mem[8'h00]), 32'h2222);
        chk("wrap_m01", 32'(mem[8'h01]), 32'h3333);
        chk("wrap_checksum", 32'(checksum), 32'h6666);

        // Zero length
        run_cmd(1'b0, 8'h10, 8'h40, 9'd0, 16'h0000, nd, nw, fw, lw, nb);
        chk("len0_done_cycle", 32'(nd), 32'd1);
        chk("len0_nwr", 32'(nw), 32'd0);
        chk("len0_busy_cycles", 32'(nb), 32'd0);
        chk("len0_checksum", 32'(checksum), 32'h0);

        // Fill with clamped length: 300 -> 256 words; 256*0x5A5A mod 2^16 = 0x5A00
        run_cmd(1'b1, 8'h00, 8'h00, 9'd300, 16'h5A5A, nd, nw, fw, lw, nb);
        chk("fill_done_cycle", 32'(nd), 32'd258);
        chk("fill_nwr", 32'(nw), 32'd256);
        chk("fill_checksum", 32'(checksum), 32'h5A00);
        chk("fill_m00", 32'(mem[8'h00]), 32'h5A5A);
        chk("fill_m83", 32'(mem[8'h83]), 32'h5A5A);
        chk("fill_mFF", 32'(mem[8'hFF]), 32'h5A5A);

        // Overlap dst = src+1: shifted copy of old data
        for (int i = 0; i < 4; i++) preload(8'(8'h20 + i), 16'(i + 1));
        run_cmd(1'b0, 8'h20, 8'h21, 9'd3, 16'h0000, nd, nw, fw, lw, nb);
        chk("ovl1_m21", 32'(mem[8'h21]), 32'h0001);
        chk("ovl1_m22", 32'(mem[8'h22]), 32'h0002);
        chk("ovl1_m23", 32'(mem[8'h23]), 32'h0003);
        chk("ovl1_checksum", 32'(checksum), 32'h0006);

        // Overlap dst = src+2, len 2
        for (int i = 0; i < 4; i++) preload(8'(8'h20 + i), 16'(i + 1));
        run_cmd(1'b0, 8'h20, 8'h22, 9'd2, 16'h0000, nd, nw, fw, lw, nb);
        chk("ovl2_m21", 32'(mem[8'h21]), 32'h0002);
        chk("ovl2_m22", 32'(mem[8'h22]), 32'h0001);
        chk("ovl2_m23", 32'(mem[8'h23]), 32'h0002);

        // Abort in RUN k=2 of a len=6 copy, with an ignored start during RUN
        for (int i = 0; i < 6; i++) preload(8'(8'h40 + i), 16'(8'h11 * (i + 1)));
        wr0 = wr_total; dn0 = done_total;
        @(negedge clk);
        start = 1'b1; op = 1'b0; src_addr = 8'h40; dst_addr = 8'h90; len = 9'd6;
        @(posedge clk);                       // accept edge E
        @(negedge clk);                       // cycle E+1, k=0: second start (ignored)
        dst_addr = 8'hC0; len = 9'd1; op = 1'b1; pattern = 16'hFFFF;
        chk("abort_busy_k0", 32'(busy), 32'd1);
        @(negedge clk);                       // cycle E+2, k=1
        start = 1'b0;
        chk("abort_wr0_addr", 32'(mem_wt_addr), 32'h90);
        @(negedge clk);                       // cycle E+3, k=2
        abort = 1'b1;
        chk("abort_wr1_addr", 32'(mem_wt_addr), 32'h91);
        @(negedge clk);                       // cycle E+4: back in IDLE
        abort = 1'b0;
        chk("abort_busy_after", 32'(busy), 32'd0);
        chk("abort_wt_en_after", 32'(mem_wt_en), 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_nwr", 32'(wr_total - wr0), 32'd2);
        chk("abort_no_done", 32'(done_total - dn0), 32'd0);
        chk("abort_checksum", 32'(checksum), 32'h0033);
        chk("abort_m90", 32'(mem[8'h90]), 32'h0011);
        chk("abort_m91", 32'(mem[8'h91]), 32'h0022);
        chk("abort_m92", 32'(mem[8'h92]), 32'h5A5A);
        chk("ignored_mC0", 32'(mem[8'hC0]), 32'h5A5A);

        // Asynchronous reset mid-RUN of a len=8 copy
        @(negedge clk);
        start = 1'b1; op = 1'b0; src_addr = 8'h40; dst_addr = 8'hA0; len = 9'd8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);            // cycle E+4, writes in progress
        chk("midrun_wt_en", 32'(mem_wt_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wt_en", 32'(mem_wt_en), 32'd0);
        chk("midrst_wt_addr", 32'(mem_wt_addr), 32'h0);
        chk("midrst_data_wt", 32'(mem_data_wt), 32'h0);
        chk("midrst_rd_addr", 32'(mem_rd_addr), 32'h0);
        chk("midrst_checksum", 32'(checksum), 32'h0);
        wr0 = wr_total; dn0 = done_total;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_no_writes", 32'(wr_total - wr0), 32'd0);
        chk("midrst_no_done", 32'(done_total - dn0), 32'd0);
        chk("midrst_idle_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
